// File: rtl/exec_pkg.sv
// Shared types for the execution-phase sequencer: state and sub-phase codes,
// enter-request priority order, and the next-state pick.
package exec_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_PP, ST_WE, ST_WP, ST_WA, ST_WZ, ST_WD, ST_WR, ST_WW, ST_WM, ST_WX
  } state_t;

  typedef enum logic [1:0] {PH_S1, PH_WAIT, PH_S2} phase_t;

  localparam int NUM_EW    = 9;
  localparam int NUM_LINES = 10;

  // Index 0 is the highest-priority enter request (ewe), index 8 the lowest (ewx).
  localparam state_t EW_ORDER [NUM_EW] = '{
    ST_WE, ST_WP, ST_WA, ST_WZ, ST_WD, ST_WR, ST_WW, ST_WM, ST_WX
  };

  function automatic state_t pick_next(input logic [NUM_EW-1:0] ew);
    state_t nxt;
    nxt = ST_IDLE;
    for (int i = NUM_EW - 1; i >= 0; i--)
      if (ew[i]) nxt = EW_ORDER[i];
    return nxt;
  endfunction

  function automatic logic is_mem(input state_t s);
    return (s == ST_WR) || (s == ST_WW) || (s == ST_WM);
  endfunction

  // Active-low one-hot decode; bit 0 is PP, bit 9 is WX, IDLE drives all high.
  function automatic logic [NUM_LINES-1:0] state_lines(input state_t s);
    logic [NUM_LINES-1:0] l;
    for (int i = 0; i < NUM_LINES; i++)
      l[i] = !(s == state_t'(4'(i + 1)));
    return l;
  endfunction

endpackage

// File: rtl/mem_timeout.sv
// Loadable 8-bit down-counter guarding the memory handshake; expired flags the
// WAIT cycle whose decrement would bring the count to zero.
module mem_timeout (
  input  logic       clk_sys,
  input  logic       clr,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (clr)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != 8'd0)  cnt <= cnt - 8'd1;
  end

  assign expired = en && (cnt <= 8'd1);

endmodule

// File: rtl/exec_phase_seq.sv
// Execution-phase sequencer: one-hot active-low state lines, STROB1/STROB2,
// memory handshake with timeout, and next-state selection from EW/EKC requests.
module exec_phase_seq
  import exec_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk_sys,
  input  logic clr,
  input  logic start,
  input  logic ewe,
  input  logic ewp,
  input  logic ewa,
  input  logic ewz,
  input  logic ewd,
  input  logic ewr,
  input  logic eww,
  input  logic ewm,
  input  logic ewx,
  input  logic ekc_1,
  input  logic ekc_2,
  input  logic mem_ok,
  output logic pp_,
  output logic we_,
  output logic wp_,
  output logic wa_,
  output logic wz_,
  output logic wd_,
  output logic wr_,
  output logic ww_,
  output logic wm_,
  output logic wx_,
  output logic strob1,
  output logic strob2,
  output logic mem_req,
  output logic mem_wr,
  output logic busy,
  output logic done,
  output logic alarm
);

  state_t st_q, st_n, pick;
  phase_t ph_q, ph_n;
  logic   done_n, alarm_n;
  logic   tmo_load, tmo_en, tmo_exp;

  logic [NUM_EW-1:0]    ew;
  logic [NUM_LINES-1:0] lines_q;

  assign ew = {ewx, ewm, eww, ewr, ewd, ewz, ewa, ewp, ewe};

  mem_timeout u_tmo (
    .clk_sys  (clk_sys),
    .clr      (clr),
    .load     (tmo_load),
    .en       (tmo_en),
    .load_val (8'(MEM_TIMEOUT)),
    .expired  (tmo_exp)
  );

  always_comb begin
    st_n     = st_q;
    ph_n     = ph_q;
    done_n   = 1'b0;
    alarm_n  = 1'b0;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;
    pick     = pick_next(ew);
    if (st_q == ST_IDLE) begin
      ph_n = PH_S1;
      if (start) st_n = ST_PP;
    end else begin
      unique case (ph_q)
        PH_S1: begin
          ph_n     = is_mem(st_q) ? PH_WAIT : PH_S2;
          tmo_load = is_mem(st_q);
        end
        PH_WAIT: begin
          tmo_en = 1'b1;
          // A completion arriving on the expiry cycle still counts as success.
          if (mem_ok) begin
            ph_n = PH_S2;
          end else if (tmo_exp) begin
            st_n    = ST_IDLE;
            ph_n    = PH_S1;
            alarm_n = 1'b1;
          end
        end
        PH_S2: begin
          ph_n = PH_S1;
          if (ekc_1 || ekc_2) begin
            st_n   = ST_IDLE;
            done_n = 1'b1;
          end else begin
            st_n    = pick;
            alarm_n = (pick == ST_IDLE);
          end
        end
        default: begin
          st_n = ST_IDLE;
          ph_n = PH_S1;
        end
      endcase
    end
  end

  // All outputs are decoded from the next state so they leave flops directly.
  always_ff @(posedge clk_sys) begin
    if (clr) begin
      st_q    <= ST_IDLE;
      ph_q    <= PH_S1;
      lines_q <= '1;
      strob1  <= 1'b0;
      strob2  <= 1'b0;
      mem_req <= 1'b0;
      mem_wr  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      st_q    <= st_n;
      ph_q    <= ph_n;
      lines_q <= state_lines(st_n);
      strob1  <= (st_n != ST_IDLE) && (ph_n == PH_S1);
      strob2  <= (st_n != ST_IDLE) && (ph_n == PH_S2);
      mem_req <= is_mem(st_n) && (ph_n != PH_S2);
      mem_wr  <= (st_n == ST_WW);
      busy    <= (st_n != ST_IDLE);
      done    <= done_n;
      alarm   <= alarm_n;
    end
  end

  assign pp_ = lines_q[0];
  assign we_ = lines_q[1];
  assign wp_ = lines_q[2];
  assign wa_ = lines_q[3];
  assign wz_ = lines_q[4];
  assign wd_ = lines_q[5];
  assign wr_ = lines_q[6];
  assign ww_ = lines_q[7];
  assign wm_ = lines_q[8];
  assign wx_ = lines_q[9];

endmodule

// File: tb/tb_exec_phase_seq.sv
// Self-checking bench for exec_phase_seq: two instances (default timeout and
// timeout 3) driven in parallel; each scenario checks the selected instance.
module tb_exec_phase_seq;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       clr = 1'b1, start = 1'b0, mem_ok = 1'b0;
  logic [8:0] ew_drv = '0;
  logic [1:0] ekc_drv = '0;

  wire [9:0] ln0, ln1;
  wire s1_0, s2_0, rq0, wr0, bz0, dn0, al0;
  wire s1_1, s2_1, rq1, wr1, bz1, dn1, al1;
  wire [16:0] o0 = {ln0, s1_0, s2_0, rq0, wr0, bz0, dn0, al0};
  wire [16:0] o1 = {ln1, s1_1, s2_1, rq1, wr1, bz1, dn1, al1};

  exec_phase_seq #(.MEM_TIMEOUT(255)) dut0 (
    .clk_sys(clk_sys), .clr(clr), .start(start),
    .ewe(ew_drv[0]), .ewp(ew_drv[1]), .ewa(ew_drv[2]), .ewz(ew_drv[3]), .ewd(ew_drv[4]),
    .ewr(ew_drv[5]), .eww(ew_drv[6]), .ewm(ew_drv[7]), .ewx(ew_drv[8]),
    .ekc_1(ekc_drv[0]), .ekc_2(ekc_drv[1]), .mem_ok(mem_ok),
    .pp_(ln0[9]), .we_(ln0[8]), .wp_(ln0[7]), .wa_(ln0[6]), .wz_(ln0[5]),
    .wd_(ln0[4]), .wr_(ln0[3]), .ww_(ln0[2]), .wm_(ln0[1]), .wx_(ln0[0]),
    .strob1(s1_0), .strob2(s2_0), .mem_req(rq0), .mem_wr(wr0),
    .busy(bz0), .done(dn0), .alarm(al0)
  );

  exec_phase_seq #(.MEM_TIMEOUT(3)) dut1 (
    .clk_sys(clk_sys), .clr(clr), .start(start),
    .ewe(ew_drv[0]), .ewp(ew_drv[1]), .ewa(ew_drv[2]), .ewz(ew_drv[3]), .ewd(ew_drv[4]),
    .ewr(ew_drv[5]), .eww(ew_drv[6]), .ewm(ew_drv[7]), .ewx(ew_drv[8]),
    .ekc_1(ekc_drv[0]), .ekc_2(ekc_drv[1]), .mem_ok(mem_ok),
    .pp_(ln1[9]), .we_(ln1[8]), .wp_(ln1[7]), .wa_(ln1[6]), .wz_(ln1[5]),
    .wd_(ln1[4]), .wr_(ln1[3]), .ww_(ln1[2]), .wm_(ln1[1]), .wx_(ln1[0]),
    .strob1(s1_1), .strob2(s2_1), .mem_req(rq1), .mem_wr(wr1),
    .busy(bz1), .done(dn1), .alarm(al1)
  );

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  // State numbering of the model: 0 IDLE, 1 PP, 2 WE, 3 WP, 4 WA, 5 WZ, 6 W&,
  // 7 WR, 8 WW, 9 WM, 10 WX.
  function automatic logic [16:0] expv(input int st, input bit s1, input bit s2,
                                       input bit dn, input bit al);
    logic [9:0] l;
    bit mem;
    l = '1;
    if (st != 0) l[10 - st] = 1'b0;
    mem = (st == 7) || (st == 8) || (st == 9);
    return {l, s1, s2, mem && !s2, st == 8, st != 0, dn, al};
  endfunction

  function automatic int tb_pick(input logic [8:0] ew);
    for (int i = 0; i < 9; i++)
      if (ew[i]) return i + 2;
    return 0;
  endfunction

  function automatic logic [16:0] obs();
    return (sel != 0) ? o1 : o0;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic quiet();
    start = 1'b0; ew_drv = '0; ekc_drv = '0; mem_ok = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    quiet();
  endtask

  // Plays one state from its S1 cycle. k is the WAIT cycle carrying mem_ok;
  // k beyond the timeout means mem_ok never comes. Returns the following state.
  task automatic play_state(input int st, input int k, input logic [8:0] ew_s2,
                            input logic [1:0] ekc_s2, input string nm, output int nxt);
    int T, jmax;
    bit mem;
    logic [16:0] e;
    T    = (sel != 0) ? 3 : 255;
    mem  = (st == 7) || (st == 8) || (st == 9);
    jmax = (k > T) ? T : k;
    e = expv(st, 1, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL %s s1 st=%0d: got %h want %h", nm, st, obs(), e); end
    ew_drv = 9'($urandom); ekc_drv = 2'($urandom); mem_ok = 1'($urandom); start = 1'($urandom);
    if (mem) begin
      for (int j = 1; j <= jmax; j++) begin
        tick();
        e = expv(st, 0, 0, 0, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL %s wait%0d st=%0d: got %h want %h", nm, j, st, obs(), e); end
        ew_drv = 9'($urandom); ekc_drv = 2'($urandom); start = 1'($urandom);
        mem_ok = (j == k);
      end
      if (k > T) begin
        tick();
        e = expv(0, 0, 0, 0, 1);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL %s timeout st=%0d: got %h want %h", nm, st, obs(), e); end
        quiet();
        nxt = 0;
        return;
      end
    end
    tick();
    e = expv(st, 0, 1, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL %s s2 st=%0d: got %h want %h", nm, st, obs(), e); end
    ew_drv = ew_s2; ekc_drv = ekc_s2; mem_ok = 1'($urandom); start = 1'($urandom);
    tick();
    quiet();
    if (ekc_s2 != 2'b00) begin
      nxt = 0;
      e = expv(0, 0, 0, 1, 0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL %s done st=%0d: got %h want %h", nm, st, obs(), e); end
    end else begin
      nxt = tb_pick(ew_s2);
      if (nxt == 0) begin
        e = expv(0, 0, 0, 0, 1);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL %s deadend st=%0d: got %h want %h", nm, st, obs(), e); end
      end
    end
  endtask

  task automatic begin_instr();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b1; ew_drv = '1; ekc_drv = '1; mem_ok = 1'b1;
    tick();
    total++;
    if (o0 !== expv(0, 0, 0, 0, 0)) begin bad++; $display("FAIL reset dut0: got %h want %h", o0, expv(0, 0, 0, 0, 0)); end
    total++;
    if (o1 !== expv(0, 0, 0, 0, 0)) begin bad++; $display("FAIL reset dut1: got %h want %h", o1, expv(0, 0, 0, 0, 0)); end
    clr = 1'b0;
    quiet();
  endtask

  task automatic test_clr_mid_wait();
    logic [16:0] e;
    sel = 0;
    do_reset();
    begin_instr();
    tick();
    ew_drv = 9'h020;
    tick();
    quiet();
    tick();
    tick();
    e = expv(7, 0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL clrwait pre: got %h want %h", obs(), e); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = expv(0, 0, 0, 0, 0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL clrwait idle%0d: got %h want %h", i, obs(), e); end
      tick();
    end
  endtask

  task automatic test_simple();
    int n;
    logic [16:0] e;
    sel = 0;
    do_reset();
    begin_instr();
    play_state(1, 0, 9'h001, 2'b00, "simple", n);
    play_state(n, 0, 9'h000, 2'b01, "simple", n);
    tick();
    e = expv(0, 0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL simple done_once: got %h want %h", obs(), e); end
  endtask

  task automatic test_priority();
    int n;
    sel = 0;
    do_reset();
    begin_instr();
    play_state(1, 0, 9'h124, 2'b00, "prio", n);
    play_state(n, 0, 9'h100, 2'b10, "prio", n);
  endtask

  task automatic test_mem_handshake();
    int n;
    sel = 0;
    do_reset();
    begin_instr();
    play_state(1, 0, 9'h040, 2'b00, "memww", n);
    play_state(n, 4, 9'h000, 2'b01, "memww", n);
  endtask

  task automatic test_timeout();
    int n;
    logic [16:0] e;
    sel = 1;
    do_reset();
    begin_instr();
    play_state(1, 0, 9'h080, 2'b00, "tmo", n);
    play_state(n, 4, 9'h000, 2'b01, "tmo", n);
    tick();
    e = expv(0, 0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL tmo alarm_once: got %h want %h", obs(), e); end
    // mem_ok on the very cycle the count runs out is still a success
    begin_instr();
    play_state(1, 0, 9'h020, 2'b00, "tmo_edge", n);
    play_state(n, 3, 9'h000, 2'b10, "tmo_edge", n);
  endtask

  task automatic test_dead_end();
    int n;
    logic [16:0] e;
    sel = 0;
    do_reset();
    begin_instr();
    play_state(1, 0, 9'h000, 2'b00, "dead", n);
    tick();
    e = expv(0, 0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL dead alarm_once: got %h want %h", obs(), e); end
  endtask

  task automatic test_back_to_back();
    int n;
    sel = 0;
    do_reset();
    begin_instr();
    play_state(1, 0, 9'h100, 2'b00, "b2b", n);
    for (int i = 0; i < 3; i++)
      play_state(n, 0, 9'h100, 2'b00, "b2b", n);
    play_state(n, 0, 9'h000, 2'b01, "b2b", n);
  endtask

  task automatic test_random();
    int cur, steps, k;
    logic [8:0] ew;
    logic [1:0] ekc;
    sel = 1;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      begin_instr();
      cur = 1;
      steps = 0;
      while (cur != 0) begin
        ew = 9'(1 << $urandom_range(0, 8)) | (9'($urandom) & 9'($urandom) & 9'($urandom));
        if ($urandom_range(0, 9) == 0) ew = '0;
        ekc = 2'b00;
        if (steps >= 6 || $urandom_range(0, 4) == 0) ekc = 2'($urandom_range(1, 3));
        k = $urandom_range(1, 4);
        play_state(cur, k, ew, ekc, "rand", cur);
        steps++;
      end
    end
  endtask

  initial begin
    quiet();
    clr = 1'b1;
    tick();
    test_reset();
    test_clr_mid_wait();
    test_simple();
    test_priority();
    test_mem_handshake();
    test_timeout();
    test_dead_end();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/exec_phase_seq.md
# exec_phase_seq

Execution-phase sequencer for the CPU control path. It holds the one-hot execution state (PP, WE, WP, WA, WZ, W&, WR, WW, WM, WX) that the instruction decoder reads. It generates the STROB1/STROB2 pair for each state, and picks the next state from the decoder's enter-state requests (EW*) and cycle-end requests (EKC*). Memory and I/O states (WR, WW, WM) stall on a memory handshake guarded by a timeout.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: cycles to wait for `mem_ok` before alarm; legal range 1..255.

Ports:
- `clk_sys` in 1: system clock; single clock domain.
- `clr` in 1: reset, synchronous, active-high.
- `start` in 1: begin execution of the instruction latched in IR; honoured only in IDLE.
- `ewe, ewp, ewa, ewz, ew$, ewr, eww, ewm, ewx` in 1 each: enter-state requests from the decoder.
- `ekc_1, ekc_2` in 1 each: cycle-end requests from the decoder.
- `mem_ok` in 1: memory/I/O transfer complete.
- `pp_, we_, wp_, wa_, wz_, w$_, wr_, ww_, wm_, wx_` out 1 each: state lines, active-low; at most one is low.
- `strob1, strob2` out 1 each: one-cycle strobes.
- `mem_req` out 1: transfer request, held in WR/WW/WM until `mem_ok` or timeout.
- `mem_wr` out 1: 1 in WW, 0 otherwise.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on normal cycle end.
- `alarm` out 1: one-cycle pulse on timeout or dead-end.

## Operation
- State set: IDLE, PP, WE, WP, WA, WZ, WD (W&), WR, WW, WM, WX. Each non-IDLE state has sub-phases S1 -> [WAIT] -> S2.
- IDLE -> PP when `start`=1.
- S1 cycle: `strob1`=1. Memory states assert `mem_req` from S1 onward.
- WAIT applies only to WR, WW and WM. The sequencer stays in WAIT until `mem_ok`=1. The timeout counter loads `MEM_TIMEOUT` at S1 and decrements each WAIT cycle. If it reaches 0 with no `mem_ok`: `alarm` pulses, state goes to IDLE, no S2.
- S2 cycle: `strob2`=1. The next state is sampled on this cycle:
  - If `ekc_1|ekc_2`: go to IDLE and pulse `done`. Cycle end wins over any enter request.
  - Otherwise take the first asserted enter request, priority ewe > ewp > ewa > ewz > ew$ > ewr > eww > ewm > ewx. The next state starts at S1.
  - If nothing is asserted: `alarm` pulses, state goes to IDLE.
- Re-entering the same state is legal (e.g. WX -> WX for shifts). It restarts S1.
- `mem_ok` outside WAIT is ignored. `mem_ok` in the same cycle the counter hits 0 counts as success.
- `start` while busy is ignored.
- `clr` at any cycle: next cycle is IDLE, counter 0, all pulses 0. A pending `mem_req` is dropped.

## Timing
- Reset values: all state lines 1 (inactive), `strob1=strob2=mem_req=mem_wr=done=alarm=busy=0`.
- Every output is registered, with no combinational path from inputs to outputs.
- `start` at cycle n: `pp_`=0 and `strob1`=1 at n+1, `strob2`=1 at n+2.
- Non-memory state: 2 cycles (S1, S2).
- Memory state: S1, then WAIT for k cycles, then S2.
  - `mem_ok` sampled in WAIT cycle j gives S2 at WAIT+j+1.
  - Minimum memory state length is 3 cycles.
- `done` and `alarm` are asserted in the first IDLE cycle after the triggering S2 or timeout.
- The state line stays low through all sub-phases of its state.

## Structure
- Shared package `exec_pkg`:
  - state enum (11 codes) and sub-phase enum (S1/WAIT/S2);
  - priority-order constant;
  - function `pick_next(ew vector) -> state`.
- One sub-module `mem_timeout`: loadable 8-bit down-counter with `load`, `en`, `expired`.
- The top level holds the state and sub-phase registers, the one-hot active-low decode, and the strobe and pulse registers.

## Test plan
- Reset mid-WAIT: `clr` during WR WAIT -> next cycle all state lines 1, `mem_req`=0; no `done` or `alarm`.
- Simple sequence: `start`, then in PP S2 assert `ewe`, then in WE S2 assert `ekc_1`.
  - PP 2 cycles, WE 2 cycles, then IDLE with `done` pulsed once.
  - Total 5 cycles from `start` to `done`.
- Priority: in S2 drive `ewa=ewr=ewx=1` -> WA entered. Drive `ewx=ekc_2=1` -> IDLE with `done`.
- Memory handshake: enter WW and raise `mem_ok` after 4 WAIT cycles.
  - `mem_req=mem_wr=1` for 5 cycles.
  - `strob2` in the cycle after `mem_ok`.
- Timeout: `MEM_TIMEOUT=3`, enter WM, never raise `mem_ok` -> `alarm` pulse after 3 WAIT cycles, then IDLE with no `strob2`.
- Dead-end and back-to-back:
  - No EW/EKC in S2 -> `alarm`, IDLE.
  - `ewx` asserted in each of 3 consecutive WX S2 cycles -> 3 S1/S2 pairs, `wx_` held low continuously.
